universal_ff_bank: RTL and testbench

UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

---
 rtl/ff_pkg.sv | 14 +
 rtl/ff_cell.sv | 58 +++++
 rtl/universal_ff_bank.sv | 72 +++++++
 tb/tb_universal_ff_bank.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared flip-flop personality encodings for the universal flip-flop bank.
// Pure declarations; no logic, no latency.
package ff_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_e;

endpackage

// File: rtl/ff_cell.sv
// One bank bit: D/T/SR/JK next-state decode plus its register; 1 clk latency.
// No backpressure; ill is a combinational flag for an enabled SR 11 request.
module ff_cell
    import ff_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  a,
    input  logic  b,
    output logic  q,
    output logic  ill
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        ill = 1'b0;
        if (en) begin
            case (mode)
                MODE_D:  q_d = a;
                MODE_T:  q_d = q_q ^ a;
                MODE_SR: begin
                    // 11 is a defined hold so q never goes unknown; it is only flagged.
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   ill = 1'b1;
                        default: q_d = q_q;
                    endcase
                end
                MODE_JK: begin
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-bit bank of mode-selectable flip-flops with a registered illegal-SR pulse
// and saturating error counter; 1 clk latency on q/illegal/err_cnt, no backpressure.
module universal_ff_bank
    import ff_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             illegal,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    mode_e            mode_s;
    logic [WIDTH-1:0] ill_vec;
    logic             ill_any;
    logic             illegal_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic [ERR_W-1:0] err_cnt_q;

    assign mode_s = mode_e'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .mode (mode_s),
            .a    (a[i]),
            .b    (b[i]),
            .q    (q[i]),
            .ill  (ill_vec[i])
        );
    end

    // One event per cycle no matter how many bits requested SR 11.
    assign ill_any = |ill_vec;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = ill_any ? ERR_W'(1) : '0;
        end else if (ill_any && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            illegal_q <= ill_any;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign qn      = ~q;
    assign illegal = illegal_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed-vector bench: driver queues hand-computed post-edge state, a monitor
// compares it against the bank shortly after every rising edge.
module tb_universal_ff_bank;
    import ff_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned ERR_W = 2;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] q;
        logic             ill;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             illegal;
    logic [ERR_W-1:0] err_cnt;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_failed = 0;
    int   n_step   = 0;

    universal_ff_bank #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .clr_err (clr_err),
        .q       (q),
        .qn      (qn),
        .illegal (illegal),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the bank presents new state every edge; pop one expectation per edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (q !== e.q || qn !== ~e.q || illegal !== e.ill || err_cnt !== e.cnt) begin
                n_failed++;
                $display("FAIL step%0d: got q=%h qn=%h ill=%b cnt=%0d, want q=%h qn=%h ill=%b cnt=%0d",
                         e.idx, q, qn, illegal, err_cnt, e.q, ~e.q, e.ill, e.cnt);
            end
        end
    end

    task automatic check_now(input string name, input logic [WIDTH-1:0] eq,
                             input logic ei, input logic [ERR_W-1:0] ec);
        n_tests++;
        if (q !== eq || qn !== ~eq || illegal !== ei || err_cnt !== ec) begin
            n_failed++;
            $display("FAIL %s: got q=%h qn=%h ill=%b cnt=%0d, want q=%h qn=%h ill=%b cnt=%0d",
                     name, q, qn, illegal, err_cnt, eq, ~eq, ei, ec);
        end
    endtask

    task automatic step(input logic e, input mode_e m, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic c,
                        input logic [WIDTH-1:0] eq, input logic ei,
                        input logic [ERR_W-1:0] ec);
        exp_t x;
        en      = e;
        mode    = m;
        a       = av;
        b       = bv;
        clr_err = c;
        x.idx = n_step;
        x.q   = eq;
        x.ill = ei;
        x.cnt = ec;
        exp_q.push_back(x);
        n_step++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = MODE_D; a = '0; b = '0; clr_err = 1'b0;
        #3;
        check_now("reset_state", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;

        // JK toggle
        step(1, MODE_JK, 8'hFF, 8'hFF, 0, 8'hFF, 0, 2'd0);
        step(1, MODE_JK, 8'hFF, 8'hFF, 0, 8'h00, 0, 2'd0);
        step(1, MODE_JK, 8'hFF, 8'hFF, 0, 8'hFF, 0, 2'd0);
        step(1, MODE_D,  8'h00, 8'hFF, 0, 8'h00, 0, 2'd0);
        // SR set / clear / illegal hold
        step(1, MODE_SR, 8'h0F, 8'h00, 0, 8'h0F, 0, 2'd0);
        step(1, MODE_SR, 8'h00, 8'h03, 0, 8'h0C, 0, 2'd0);
        step(1, MODE_SR, 8'h81, 8'h81, 0, 8'h0C, 1, 2'd1);
        step(1, MODE_SR, 8'h00, 8'h00, 0, 8'h0C, 0, 2'd1);
        // saturation and clear
        step(1, MODE_SR, 8'h00, 8'h00, 1, 8'h0C, 0, 2'd0);
        step(1, MODE_SR, 8'h81, 8'h81, 0, 8'h0C, 1, 2'd1);
        step(1, MODE_SR, 8'h81, 8'h81, 0, 8'h0C, 1, 2'd2);
        step(1, MODE_SR, 8'h81, 8'h81, 0, 8'h0C, 1, 2'd3);
        step(1, MODE_SR, 8'h81, 8'h81, 0, 8'h0C, 1, 2'd3);
        step(1, MODE_SR, 8'h81, 8'h81, 0, 8'h0C, 1, 2'd3);
        step(1, MODE_SR, 8'h81, 8'h81, 1, 8'h0C, 1, 2'd1);
        // disabled: no update, no illegal event
        step(0, MODE_SR, 8'hFF, 8'hFF, 0, 8'h0C, 0, 2'd1);
        step(0, MODE_JK, 8'hFF, 8'hFF, 0, 8'h0C, 0, 2'd1);
        // T with enable gating, then switch to D
        step(1, MODE_D,  8'h00, 8'h00, 0, 8'h00, 0, 2'd1);
        step(1, MODE_T,  8'h55, 8'h00, 0, 8'h55, 0, 2'd1);
        step(0, MODE_T,  8'h55, 8'h00, 0, 8'h55, 0, 2'd1);
        step(1, MODE_T,  8'h55, 8'h00, 0, 8'h00, 0, 2'd1);
        step(1, MODE_D,  8'hA5, 8'h00, 0, 8'hA5, 0, 2'd1);
        step(1, MODE_SR, 8'h01, 8'h01, 0, 8'hA5, 1, 2'd2);
        step(0, MODE_D,  8'h00, 8'h00, 0, 8'hA5, 0, 2'd2);

        // async reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        check_now("async_reset", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        step(1, MODE_D, 8'hFF, 8'h00, 1, 8'h00, 0, 2'd0);
        rst = 1'b1;
        // first edge after release, then JK set/clear, hold, T invert
        step(1, MODE_D,  8'h3C, 8'h00, 0, 8'h3C, 0, 2'd0);
        step(1, MODE_JK, 8'h0F, 8'hF0, 0, 8'h0F, 0, 2'd0);
        step(1, MODE_JK, 8'h00, 8'h00, 0, 8'h0F, 0, 2'd0);
        step(1, MODE_T,  8'hFF, 8'h00, 0, 8'hF0, 0, 2'd0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
